// File: rtl/cmn_pwm_deadtime.sv
// cmn_pwm_deadtime -- gate-drive conditioning for N_PH half-bridges.
// Registers the PWM requests and inserts a programmable dead time on every
// gate turn-on. It also blocks shoot-through requests and forces all gates
// off on fault or disable. A {1,1} request pair raises a sticky error.
//
// Optional build macro: CMN_PWM_MIN_PULSE_EN
//   When defined, every gate stays on for at least MIN_ON clocks once it has
//   turned on. Fault and disable still force the gates off immediately.
//
// Per-phase FSM
//   state | meaning
//   OFF   | both gates off, no request pending
//   DT    | both gates off, counting dead time toward target side (tgt_hi)
//   ON_HI | high-side gate on
//   ON_LO | low-side gate on
module cmn_pwm_deadtime #(
  parameter int N_PH   = 3,
  parameter int DT_W   = 8,
  parameter int MIN_ON = 4
) (
  input  logic                OPB_CLK,
  input  logic                OPB_RST,
  input  logic [2*N_PH-1:0]   pwm_i,
  input  logic                en_i,
  input  logic                fault_i,
  input  logic [DT_W-1:0]     dead_cnt_i,
  input  logic                clr_err_i,
  output logic [2*N_PH-1:0]   gate_o,
  output logic [N_PH-1:0]     dt_active_o,
  output logic                shoot_err_o
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DT    = 2'd1,
    ST_ON_HI = 2'd2,
    ST_ON_LO = 2'd3
  } state_t;

  logic [2*N_PH-1:0] pwm_q;
  logic [N_PH-1:0]   shoot_ph;
  logic              force_off;

  // fault and enable act on the raw pins so the gates drop on the same edge
  assign force_off = fault_i | ~en_i;

  // single input register stage for the PWM requests
  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RST) pwm_q <= '0;
    else          pwm_q <= pwm_i;
  end

  for (genvar k = 0; k < N_PH; k++) begin : g_ph
    logic            req_hi;
    logic            req_lo;
    state_t          state_q;
    state_t          state_d;
    logic            tgt_hi_q;
    logic            tgt_hi_d;
    logic [DT_W-1:0] cnt_q;
    logic [DT_W-1:0] cnt_d;
    logic            gate_hi_d;
    logic            gate_lo_d;
    logic            dt_d;
    logic            gate_hi_q;
    logic            gate_lo_q;
    logic            dt_q;
    logic            hold_on;

    // {1,1} decodes as no request, so the phase falls back to OFF
    assign req_hi      = pwm_q[2*k]   & ~pwm_q[2*k+1];
    assign req_lo      = pwm_q[2*k+1] & ~pwm_q[2*k];
    assign shoot_ph[k] = pwm_q[2*k]   &  pwm_q[2*k+1];

`ifdef CMN_PWM_MIN_PULSE_EN
    localparam int MW = (MIN_ON > 1) ? $clog2(MIN_ON) : 1;
    logic [MW-1:0] on_q;

    // minimum on-time counter, reloaded on every DT to ON transition
    always_ff @(posedge OPB_CLK) begin
      if (!OPB_RST || force_off)
        on_q <= '0;
      else if (state_q == ST_DT && (state_d == ST_ON_HI || state_d == ST_ON_LO))
        on_q <= MW'(MIN_ON - 1);
      else if (on_q != '0)
        on_q <= on_q - MW'(1);
    end

    assign hold_on = (on_q != '0);
`else
    assign hold_on = 1'b0;
`endif

    // state register plus registered gate and dead-time outputs
    always_ff @(posedge OPB_CLK) begin
      if (!OPB_RST) begin
        state_q   <= ST_OFF;
        tgt_hi_q  <= 1'b0;
        cnt_q     <= '0;
        gate_hi_q <= 1'b0;
        gate_lo_q <= 1'b0;
        dt_q      <= 1'b0;
      end else begin
        state_q   <= state_d;
        tgt_hi_q  <= tgt_hi_d;
        cnt_q     <= cnt_d;
        gate_hi_q <= gate_hi_d;
        gate_lo_q <= gate_lo_d;
        dt_q      <= dt_d;
      end
    end

    // next-state logic; dead_cnt_i is sampled only when entering DT
    always_comb begin
      state_d  = state_q;
      tgt_hi_d = tgt_hi_q;
      cnt_d    = cnt_q;
      if (force_off) begin
        state_d = ST_OFF;
      end else begin
        case (state_q)
          ST_OFF: begin
            if (req_hi || req_lo) begin
              state_d  = ST_DT;
              tgt_hi_d = req_hi;
              cnt_d    = dead_cnt_i;
            end
          end
          ST_DT: begin
            if (!(req_hi || req_lo)) begin
              state_d = ST_OFF;
            end else if (req_hi == tgt_hi_q) begin
              // a count of 0 or 1 both give a one-clock gap
              if (cnt_q <= DT_W'(1))
                state_d = tgt_hi_q ? ST_ON_HI : ST_ON_LO;
              else
                cnt_d = cnt_q - DT_W'(1);
            end else begin
              tgt_hi_d = req_hi;
              cnt_d    = dead_cnt_i;
            end
          end
          ST_ON_HI: begin
            if (!hold_on && !req_hi) begin
              if (req_lo) begin
                state_d  = ST_DT;
                tgt_hi_d = 1'b0;
                cnt_d    = dead_cnt_i;
              end else begin
                state_d = ST_OFF;
              end
            end
          end
          ST_ON_LO: begin
            if (!hold_on && !req_lo) begin
              if (req_hi) begin
                state_d  = ST_DT;
                tgt_hi_d = 1'b1;
                cnt_d    = dead_cnt_i;
              end else begin
                state_d = ST_OFF;
              end
            end
          end
          default: state_d = ST_OFF;
        endcase
      end
    end

    // output decode from the next state; at most one gate per phase is on
    always_comb begin
      gate_hi_d = (state_d == ST_ON_HI);
      gate_lo_d = (state_d == ST_ON_LO);
      dt_d      = (state_d == ST_DT);
    end

    assign gate_o[2*k]    = gate_hi_q;
    assign gate_o[2*k+1]  = gate_lo_q;
    assign dt_active_o[k] = dt_q;
  end

  // sticky shoot-through flag; a new request wins over a coincident clear
  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RST)       shoot_err_o <= 1'b0;
    else if (|shoot_ph) shoot_err_o <= 1'b1;
    else if (clr_err_i) shoot_err_o <= 1'b0;
  end

endmodule
